// File: rtl/fibonacci_core.sv
// fibonacci_core: divided-clock Fibonacci term generator driving the user IO pads.
// Define FIB_STEP_COUNT_EN to build the saturating step counter.
module fibonacci_core #(
  parameter int WIDTH       = 30,
  parameter int IO_LSB      = 8,
  parameter int CLOCK_WIDTH = 6,
  parameter int PADS        = 38
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   switch,
  input  logic [CLOCK_WIDTH-1:0] clock_sel,
  input  logic                   restart,
  output logic [PADS-1:0]        io_out,
  output logic [PADS-1:0]        io_oeb,
  output logic                   wrap_irq,
  output logic                   running,
  output logic [15:0]            step_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_t;

  localparam logic [PADS-1:0] TERM_MASK =
    PADS'({WIDTH{1'b1}}) << IO_LSB;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_run_nxt;
  logic                   r_running;
  logic [WIDTH-1:0]       r_cur;
  logic [WIDTH:0]         r_nxt;
  logic [CLOCK_WIDTH-1:0] r_cnt;
  logic [CLOCK_WIDTH-1:0] r_sel_q;
  logic                   r_wrap;
  logic [PADS-1:0]        r_oeb;
  logic                   w_d_nz;
  logic                   w_tick;

  assign w_d_nz = |clock_sel;
  assign w_tick = (r_state == S_RUN) && w_d_nz &&
                  (r_cnt == clock_sel - CLOCK_WIDTH'(1));

  always_ff @(posedge wb_clk_i) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (switch)  w_state_nxt = S_RUN;
      S_RUN:   if (!switch) w_state_nxt = S_PAUSE;
      S_PAUSE: if (switch)  w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // running is a flop that tracks the state register exactly
  always_comb begin
    w_run_nxt = (w_state_nxt == S_RUN);
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) r_running <= 1'b0;
    else       r_running <= w_run_nxt;
  end

  always_ff @(posedge wb_clk_i) begin
    r_sel_q <= clock_sel;
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_cur  <= '0;
      r_nxt  <= (WIDTH+1)'(1);
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_oeb  <= '1;
    end else begin
      r_wrap <= 1'b0;
      r_oeb  <= ~TERM_MASK;
      if (restart) begin
        r_cur <= '0;
        r_nxt <= (WIDTH+1)'(1);
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= '0;
        // top bit of nxt flags a term too wide to display
        if (r_nxt[WIDTH]) begin
          r_cur  <= '0;
          r_nxt  <= (WIDTH+1)'(1);
          r_wrap <= 1'b1;
        end else begin
          r_cur <= r_nxt[WIDTH-1:0];
          r_nxt <= {1'b0, r_cur} + r_nxt;
        end
      end else if (r_state != S_RUN || !w_d_nz ||
                   clock_sel != r_sel_q) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CLOCK_WIDTH'(1);
      end
    end
  end

`ifdef FIB_STEP_COUNT_EN
  logic [15:0] r_steps;

  always_ff @(posedge wb_clk_i) begin
    if (reset || restart)
      r_steps <= '0;
    else if (w_tick && r_steps != 16'hFFFF)
      r_steps <= r_steps + 16'd1;
  end

  assign step_count = r_steps;
`else
  assign step_count = 16'h0000;
`endif

  assign io_out   = PADS'(r_cur) << IO_LSB;
  assign io_oeb   = r_oeb;
  assign wrap_irq = r_wrap;
  assign running  = r_running;

endmodule

// File: tb/tb_fibonacci_core.sv
// tb_fibonacci_core: directed + random stimulus against an
// index-into-Fibonacci-table reference model.
module tb_fibonacci_core;

  localparam int WIDTH  = 30;
  localparam int IO_LSB = 8;
  localparam int CW     = 6;
  localparam int PADS   = 38;

  logic            clk = 1'b0;
  logic            reset;
  logic            sw;
  logic [CW-1:0]   sel;
  logic            restart;
  logic [PADS-1:0] io_out;
  logic [PADS-1:0] io_oeb;
  logic            wrap_irq;
  logic            running;
  logic [15:0]     step_count;

  always #5 clk = ~clk;

  fibonacci_core #(
    .WIDTH(WIDTH),
    .IO_LSB(IO_LSB),
    .CLOCK_WIDTH(CW),
    .PADS(PADS)
  ) dut (
    .wb_clk_i(clk),
    .reset(reset),
    .switch(sw),
    .clock_sel(sel),
    .restart(restart),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .wrap_irq(wrap_irq),
    .running(running),
    .step_count(step_count)
  );

  longint fib [0:63];
  int     kwrap;
  longint all_pads;
  longint oeb_live;

  int m_st;
  int m_k;
  int m_cnt;
  int m_selq;
  int m_steps;
  bit m_wrap;
  bit m_live;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit s,
                       input int d, input bit rs);
    bit tick;
    tick = (m_st == 1) && d != 0 && m_cnt == d - 1;
    if (rst) begin
      m_st = 0; m_k = 0; m_cnt = 0;
      m_steps = 0; m_wrap = 0; m_live = 0;
    end else begin
      m_wrap = 0;
      m_live = 1;
      if (rs) begin
        m_k = 0; m_cnt = 0; m_steps = 0;
      end else if (tick) begin
        m_cnt = 0;
        if (m_k == kwrap) begin
          m_k = 0;
          m_wrap = 1;
        end else begin
          m_k++;
        end
        if (m_steps < 65535) m_steps++;
      end else if (m_st != 1 || d == 0 || d != m_selq) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      case (m_st)
        0: if (s)  m_st = 1;
        1: if (!s) m_st = 2;
        default: if (s) m_st = 1;
      endcase
    end
    m_selq = d;
  endtask

  task automatic step(input bit rst, input bit s,
                      input int d, input bit rs);
    longint exp_steps;
    @(negedge clk);
    reset   = rst;
    sw      = s;
    sel     = CW'(d);
    restart = rs;
    @(posedge clk);
    model(rst, s, d, rs);
    #1;
`ifdef FIB_STEP_COUNT_EN
    exp_steps = m_steps;
`else
    exp_steps = 0;
`endif
    check("term", io_out, fib[m_k] << IO_LSB);
    check("oeb", io_oeb, m_live ? oeb_live : all_pads);
    check("wrap", wrap_irq, m_wrap);
    check("running", running, m_st == 1);
    check("steps", step_count, exp_steps);
  endtask

  function automatic longint term();
    return longint'(io_out) >> IO_LSB;
  endfunction

  initial begin
    int d;
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];
    kwrap = 0;
    while (fib[kwrap+1] < (64'd1 << WIDTH)) kwrap++;
    all_pads = (64'd1 << PADS) - 1;
    oeb_live = all_pads - (((64'd1 << WIDTH) - 1) << IO_LSB);
    m_st = 0; m_k = 0; m_cnt = 0; m_selq = 0;
    m_steps = 0; m_wrap = 0; m_live = 0;
    reset = 1; sw = 0; sel = '0; restart = 0;

    repeat (2) step(1, 0, 1, 0);
    repeat (8) step(0, 1, 1, 0);
    check("t1_13", term(), 13);

    repeat (9) step(0, 1, 3, 0);
    repeat (6) step(0, 1, 2, 0);

    step(0, 1, 1, 1);
    repeat (44) step(0, 1, 1, 0);
    check("t3_f44", term(), 701408733);
    step(0, 1, 1, 0);
    check("t3_wrap0", term(), 0);
    check("t3_irq", wrap_irq, 1);
    repeat (3) step(0, 1, 1, 0);
    check("t3_two", term(), 2);

    step(0, 1, 1, 1);
    repeat (7) step(0, 1, 1, 0);
    repeat (11) step(0, 0, 1, 0);
    check("t4_hold", term(), 21);
    repeat (3) step(0, 1, 1, 0);

    step(0, 1, 1, 1);
    repeat (6) step(0, 1, 1, 0);
    check("t5_8", term(), 8);
    step(0, 1, 1, 1);
    check("t5_zero", term(), 0);
    repeat (3) step(0, 1, 1, 0);

    step(0, 1, 1, 1);
    repeat (12) step(0, 1, 1, 0);
    check("t6_144", term(), 144);
    step(1, 1, 1, 0);
    check("t6_oeb", io_oeb, all_pads);
    check("t6_run", running, 0);
    step(0, 1, 1, 0);

    d = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) begin
        case ($urandom_range(9, 0))
          0, 1, 2, 3: d = 1;
          4, 5:       d = 2;
          6:          d = 0;
          7, 8:       d = 3;
          default:    d = int'($urandom_range(63, 4));
        endcase
      end
      step($urandom_range(199, 0) == 0,
           $urandom_range(7, 0) != 0,
           d,
           $urandom_range(59, 0) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
